// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide, one write-back pulse.
// Build option MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            wb_en_o,
   output logic [4:0]      wb_addr_o,
   output logic [XLEN-1:0] wb_data_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] ZERO    = '0;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic              dz_q, dz_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wb_en_q, wb_en_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;

   // Operand conditioning at accept time: sign flags and magnitudes.
   logic            sgn_a_in, sgn_b_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;

   always_comb begin
      sgn_a_in = rs1_i[XLEN-1] & ((op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6));
      sgn_b_in = rs2_i[XLEN-1] & ((op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6));
      a_mag_in = sgn_a_in ? -rs1_i : rs1_i;
      b_mag_in = sgn_b_in ? -rs2_i : rs2_i;
   end

   // Iteration step. acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_sub;
   logic              rem_ge;
   logic [2*XLEN-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO});
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      rem_sub  = rem_sh - {1'b0, opnd_q};
      rem_ge   = (rem_sh >= {1'b0, opnd_q});
      div_next = {(rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
   end

   // Sign correction; a zero divisor yields an all-ones quotient regardless of dividend sign.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result;

   always_comb begin
      prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quot_fix = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
      rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:                result = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    result = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:          result = quot_fix;
         default:             result = rem_fix;
      endcase
   end

   // start_i is taken only in IDLE with kill_i low; busy_o high means any start_i is dropped, not queued.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dz_d      = dz_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !kill_i) begin
               op_d    = op_i;
               rd_d    = rd_i;
               sa_d    = sgn_a_in;
               sb_d    = sgn_b_in;
               dz_d    = (rs2_i == ZERO);
               cnt_d   = '0;
               opnd_d  = op_i[2] ? b_mag_in : a_mag_in;
               acc_d   = op_i[2] ? {ZERO, a_mag_in} : {ZERO, b_mag_in};
               state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
               if (op_i[2]) begin
                  if (rs2_i == ZERO) begin
                     acc_d   = {a_mag_in, {XLEN{1'b1}}};
                     state_d = S_DONE;
                  end else if ((op_i == 3'd4) && (rs1_i == MIN_NEG) && (rs2_i == '1)) begin
                     acc_d   = {ZERO, MIN_NEG};
                     state_d = S_DONE;
                  end
               end else if ((rs1_i == ZERO) || (rs2_i == ZERO)) begin
                  acc_d   = '0;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            if (kill_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[2] ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == '1) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!kill_i && (rd_q != 5'd0)) begin
               wb_en_d   = 1'b1;
               wb_addr_d = rd_q;
               wb_data_d = result;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         op_q      <= 3'd0;
         rd_q      <= 5'd0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         dz_q      <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= 5'd0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         dz_q      <= dz_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign wb_en_o   = wb_en_q;
   assign wb_addr_o = wb_addr_q;
   assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV32M results, latency, ignored start, kill and async reset.
module tb_mdu_iter;

   logic        clk_i   = 1'b0;
   logic        rst_ni  = 1'b0;
   logic        start_i = 1'b0;
   logic        kill_i  = 1'b0;
   logic [2:0]  op_i    = 3'd0;
   logic [31:0] rs1_i   = 32'd0;
   logic [31:0] rs2_i   = 32'd0;
   logic [4:0]  rd_i    = 5'd0;
   logic        busy_o;
   logic        wb_en_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;

   int checks = 0;
   int errors = 0;
   int wb_cnt = 0;
   logic [31:0] exp_q[$];

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   mdu_iter dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .op_i      (op_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .rd_i      (rd_i),
      .kill_i    (kill_i),
      .busy_o    (busy_o),
      .wb_en_o   (wb_en_o),
      .wb_addr_o (wb_addr_o),
      .wb_data_o (wb_data_o)
   );

   // clock/reset
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (wb_en_o) wb_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic early;
      if (op[2]) early = (b == 32'd0) || ((op == 3'd4) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
      else       early = (a == 32'd0) || (b == 32'd0);
      return (EARLY_EN && early) ? 1 : 33;
   endfunction

   // driver: one operation, optional stray start pulse after poke_at edges
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int poke_at);
      int lat;
      int base;
      logic seen;
      logic [31:0] e;
      exp_q.push_back(exp);
      base = wb_cnt;
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check_val({tag, "_busy"}, 32'(busy_o), 32'd1);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
         seen = wb_en_o;
         if (lat == poke_at) begin
            start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd30;
         end else begin
            start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      check_val({tag, "_seen"}, 32'(seen), 32'd1);
      check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
      check_val({tag, "_addr"}, 32'(wb_addr_o), 32'(rd));
      e = exp_q.pop_front();
      check_val({tag, "_data"}, wb_data_o, e);
      @(posedge clk_i); #1;
      check_val({tag, "_pulse"}, 32'(wb_en_o), 32'd0);
      check_val({tag, "_idle"}, 32'(busy_o), 32'd0);
      check_val({tag, "_count"}, 32'(wb_cnt - base), 32'd1);
   endtask

   task automatic wait_quiet(input string tag, input int base);
      repeat (40) @(posedge clk_i);
      #1;
      check_val({tag, "_no_wb"}, 32'(wb_cnt - base), 32'd0);
      check_val({tag, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   initial begin
      int base;
      #12;
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_wb_en", 32'(wb_en_o), 32'd0);
      check_val("rst_wb_addr", 32'(wb_addr_o), 32'd0);
      check_val("rst_wb_data", wb_data_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, -1);
      run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, -1);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, -1);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, -1);
      run_op("mulh_n", 3'd1, 32'hFFFF_FFFD,  32'd5,         5'd9,  32'hFFFF_FFFF, -1);
      run_op("mul_z",  3'd0, 32'd0,          32'h1234_5678, 5'd10, 32'd0,         -1);
      run_op("divu",   3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        -1);
      run_op("remu",   3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         -1);
      run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFD, -1);
      run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFF, -1);
      run_op("div_nd", 3'd4, 32'd20,         32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, -1);
      run_op("rem_nd", 3'd6, 32'd20,         32'hFFFF_FFFD, 5'd16, 32'd2,         -1);
      run_op("div_z",  3'd4, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, -1);
      run_op("div_zn", 3'd4, 32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFFF, -1);
      run_op("remu_z", 3'd7, 32'd5,          32'd0,         5'd19, 32'd5,         -1);
      run_op("rem_zn", 3'd6, 32'hFFFF_FFF9,  32'd0,         5'd20, 32'hFFFF_FFF9, -1);
      run_op("div_ov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'h8000_0000, -1);
      run_op("rem_ov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'd0,         -1);

      // stray start at cycle 10 of a busy operation
      base = wb_cnt;
      run_op("ign", 3'd5, 32'd1000, 32'd10, 5'd23, 32'd100, 10);
      wait_quiet("ign_after", base + 1);

      // rd = 0 suppresses the write-back
      base = wb_cnt;
      start_only(3'd5, 32'd50, 32'd5, 5'd0);
      wait_quiet("rd0", base);

      // kill in CALC at cycle 15
      base = wb_cnt;
      start_only(3'd0, 32'd9, 32'd9, 5'd24);
      repeat (14) @(posedge clk_i);
      #1 kill_i = 1'b1;
      @(posedge clk_i); #1;
      kill_i = 1'b0;
      check_val("kill_busy", 32'(busy_o), 32'd0);
      check_val("kill_wb_en", 32'(wb_en_o), 32'd0);
      wait_quiet("kill", base);

      // kill together with start in IDLE
      base = wb_cnt;
      @(negedge clk_i);
      start_i = 1'b1; kill_i = 1'b1; op_i = 3'd5; rs1_i = 32'd8; rs2_i = 32'd2; rd_i = 5'd25;
      @(posedge clk_i); #1;
      start_i = 1'b0; kill_i = 1'b0;
      check_val("kill_start_busy", 32'(busy_o), 32'd0);
      wait_quiet("kill_start", base);

      // async reset at cycle 20 of an operation
      run_op("pre_rst", 3'd5, 32'd81, 32'd9, 5'd26, 32'd9, -1);
      base = wb_cnt;
      start_only(3'd0, 32'd6, 32'd7, 5'd27);
      repeat (19) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy_o), 32'd0);
      check_val("arst_wb_en", 32'(wb_en_o), 32'd0);
      check_val("arst_wb_addr", 32'(wb_addr_o), 32'd0);
      check_val("arst_wb_data", wb_data_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      wait_quiet("arst", base);
      run_op("post_rst", 3'd0, 32'd6, 32'd7, 5'd28, 32'd42, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
